// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the six-stage pipeline stall/flush controller:
// stage indices, FSM encoding, bubble PC and timeout default.
package pipe_ctrl_pkg;

    // Index of each register's write enable; flush bits share the index (PC has none).
    localparam int STG_PC     = 0;
    localparam int STG_IF_ID  = 1;
    localparam int STG_ID_EXE = 2;
    localparam int STG_EXE_MM1 = 3;
    localparam int STG_MM1_MM2 = 4;
    localparam int STG_MM2_WB = 5;

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_MD_BUSY = 1'b1;

    localparam logic [31:0] BUBBLE_PC = 32'h0000_0000;

    localparam int MEM_TIMEOUT_DEFAULT = 1024;

    // r0 is never a real producer, so a zero destination never creates a hazard.
    function automatic logic lu_match(input logic [4:0] src, input logic src_re,
                                      input logic [4:0] dst, input logic dst_load);
        return src_re && dst_load && (dst != 5'd0) && (src == dst);
    endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_lu_detect.sv
// Load-use comparator: two ID sources against the load destinations in EXE and MM1.
module hazard_lu_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] id_rj,
    input  logic [4:0] id_rk,
    input  logic       id_rj_re,
    input  logic       id_rk_re,
    input  logic [4:0] exe_reg_d,
    input  logic       exe_reg_d_wen,
    input  logic       exe_mm_re,
    input  logic [4:0] mm1_reg_d,
    input  logic       mm1_reg_d_wen,
    input  logic       mm1_mm_re,
    output logic       lu
);

    logic exe_load;
    logic mm1_load;

    assign exe_load = exe_reg_d_wen & exe_mm_re;
    assign mm1_load = mm1_reg_d_wen & mm1_mm_re;

    assign lu = lu_match(id_rj, id_rj_re, exe_reg_d, exe_load)
              | lu_match(id_rk, id_rk_re, exe_reg_d, exe_load)
              | lu_match(id_rj, id_rj_re, mm1_reg_d, mm1_load)
              | lu_match(id_rk, id_rk_re, mm1_reg_d, mm1_load);

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush controller: prioritised hazard resolution driving wen/flush
// of every pipeline register, plus stall statistics and a memory-timeout monitor.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rj,
    input  logic [4:0]  id_rk,
    input  logic        id_rj_re,
    input  logic        id_rk_re,
    input  logic [4:0]  exe_reg_d,
    input  logic [4:0]  mm1_reg_d,
    input  logic        exe_reg_d_wen,
    input  logic        exe_mm_re,
    input  logic        mm1_reg_d_wen,
    input  logic        mm1_mm_re,
    input  logic        exe_md_start,
    input  logic        md_done,
    input  logic        exe_br_taken,
    input  logic        if_valid,
    input  logic        mm1_mm_req,
    input  logic        dmem_req_ack,
    input  logic        mm2_mm_re,
    input  logic        dmem_rdata_valid,
    input  logic        wb_excp,
    output logic        wen_pc,
    output logic        wen_if_id,
    output logic        wen_id_exe,
    output logic        wen_exe_mm1,
    output logic        wen_mm1_mm2,
    output logic        wen_mm2_wb,
    output logic        flush_if_id,
    output logic        flush_id_exe,
    output logic        flush_exe_mm1,
    output logic        flush_mm1_mm2,
    output logic        flush_mm2_wb,
    output logic        md_ack,
    output logic        md_cancel,
    output logic [31:0] stall_cnt,
    output logic        mem_timeout_err
);

    localparam int TW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(MEM_TIMEOUT);

    logic [0:0]    state;
    logic [0:0]    state_next;
    logic          busy;
    logic          excp, mem_d, mem_r, md, br, lu, fb;
    logic [5:0]    wen;
    logic [5:1]    flush;
    logic [TW-1:0] tmo_cnt;

    hazard_lu_detect u_lu (
        .id_rj        (id_rj),
        .id_rk        (id_rk),
        .id_rj_re     (id_rj_re),
        .id_rk_re     (id_rk_re),
        .exe_reg_d    (exe_reg_d),
        .exe_reg_d_wen(exe_reg_d_wen),
        .exe_mm_re    (exe_mm_re),
        .mm1_reg_d    (mm1_reg_d),
        .mm1_reg_d_wen(mm1_reg_d_wen),
        .mm1_mm_re    (mm1_mm_re),
        .lu           (lu)
    );

    // Outputs follow the IDLE equations while rst is held, even before the first edge.
    assign busy  = (state == ST_MD_BUSY) && !rst;
    assign excp  = wb_excp;
    assign mem_d = mm2_mm_re & ~dmem_rdata_valid;
    assign mem_r = mm1_mm_req & ~dmem_req_ack;
    assign md    = busy ? ~md_done : (exe_md_start & ~md_done);
    assign br    = exe_br_taken;
    assign fb    = ~if_valid;

    // A branch sits below every freeze, so it is only taken once EXE is allowed to move.
    always_comb begin
        wen       = '1;
        flush     = '0;
        md_cancel = 1'b0;
        if (excp) begin
            flush     = '1;
            md_cancel = 1'b1;
        end else if (mem_d) begin
            wen = '0;
        end else if (mem_r) begin
            wen[STG_MM1_MM2:STG_PC] = '0;
            flush[STG_MM2_WB]       = 1'b1;
        end else if (md) begin
            wen[STG_ID_EXE:STG_PC] = '0;
            flush[STG_EXE_MM1]     = 1'b1;
        end else if (br) begin
            flush[STG_IF_ID]  = 1'b1;
            flush[STG_ID_EXE] = 1'b1;
        end else if (lu) begin
            wen[STG_IF_ID:STG_PC] = '0;
            flush[STG_ID_EXE]     = 1'b1;
        end else if (fb) begin
            flush[STG_IF_ID] = 1'b1;
        end
    end

    assign md_ack = wen[STG_EXE_MM1] & ~flush[STG_EXE_MM1] & md_done
                  & (busy | exe_md_start);

    always_comb begin
        state_next = state;
        if (!busy) begin
            if (exe_md_start && !md_done && !excp) state_next = ST_MD_BUSY;
        end else if (md_ack || excp) begin
            state_next = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            stall_cnt       <= 32'd0;
            tmo_cnt         <= '0;
            mem_timeout_err <= 1'b0;
        end else begin
            state <= state_next;
            if (!wen[STG_PC]) stall_cnt <= stall_cnt + 32'd1;
            if (mem_d || mem_r) begin
                if (tmo_cnt != TMO_MAX) tmo_cnt <= tmo_cnt + TW'(1);
                if (tmo_cnt >= TMO_MAX - TW'(1)) mem_timeout_err <= 1'b1;
            end else begin
                tmo_cnt <= '0;
            end
        end
    end

    assign wen_pc        = wen[STG_PC];
    assign wen_if_id     = wen[STG_IF_ID];
    assign wen_id_exe    = wen[STG_ID_EXE];
    assign wen_exe_mm1   = wen[STG_EXE_MM1];
    assign wen_mm1_mm2   = wen[STG_MM1_MM2];
    assign wen_mm2_wb    = wen[STG_MM2_WB];
    assign flush_if_id   = flush[STG_IF_ID];
    assign flush_id_exe  = flush[STG_ID_EXE];
    assign flush_exe_mm1 = flush[STG_EXE_MM1];
    assign flush_mm1_mm2 = flush[STG_MM1_MM2];
    assign flush_mm2_wb  = flush[STG_MM2_WB];

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a table of single-cycle vectors in IDLE plus
// hand-written multi-cycle sequences for mul/div, memory, exception and timeout.
module tb_pipe_ctrl;

    // Stimulus flag bits for one cycle of inputs.
    localparam logic [13:0] F_RJ_RE    = 14'h0001;
    localparam logic [13:0] F_RK_RE    = 14'h0002;
    localparam logic [13:0] F_EXE_LD   = 14'h0004;
    localparam logic [13:0] F_EXE_WEN  = 14'h0008;
    localparam logic [13:0] F_MM1_LD   = 14'h0010;
    localparam logic [13:0] F_MD_START = 14'h0020;
    localparam logic [13:0] F_MD_DONE  = 14'h0040;
    localparam logic [13:0] F_BR       = 14'h0080;
    localparam logic [13:0] F_FB       = 14'h0100;
    localparam logic [13:0] F_MM1_REQ  = 14'h0200;
    localparam logic [13:0] F_REQ_ACK  = 14'h0400;
    localparam logic [13:0] F_MM2_RE   = 14'h0800;
    localparam logic [13:0] F_RVALID   = 14'h1000;
    localparam logic [13:0] F_EXCP     = 14'h2000;

    // wen as {mm2_wb, mm1_mm2, exe_mm1, id_exe, if_id, pc}; flush as {mm2_wb .. if_id}.
    localparam logic [5:0] W_ALL  = 6'b111111;
    localparam logic [5:0] W_LU   = 6'b111100;
    localparam logic [5:0] W_MD   = 6'b111000;
    localparam logic [5:0] W_MEMR = 6'b100000;
    localparam logic [5:0] W_NONE = 6'b000000;

    typedef struct {
        string      name;
        logic [4:0] rj;
        logic [4:0] rk;
        logic [4:0] exe_d;
        logic [4:0] mm1_d;
        logic [13:0] flags;
        logic [5:0] e_wen;
        logic [4:0] e_flush;
        logic       e_ack;
        logic       e_cancel;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rj, id_rk, exe_reg_d, mm1_reg_d;
    logic        id_rj_re, id_rk_re, exe_reg_d_wen, exe_mm_re, mm1_reg_d_wen, mm1_mm_re;
    logic        exe_md_start, md_done, exe_br_taken, if_valid;
    logic        mm1_mm_req, dmem_req_ack, mm2_mm_re, dmem_rdata_valid, wb_excp;
    logic        wen_pc, wen_if_id, wen_id_exe, wen_exe_mm1, wen_mm1_mm2, wen_mm2_wb;
    logic        flush_if_id, flush_id_exe, flush_exe_mm1, flush_mm1_mm2, flush_mm2_wb;
    logic        md_ack, md_cancel, mem_timeout_err;
    logic [31:0] stall_cnt;

    int          total_cnt = 0;
    int          pass_cnt  = 0;
    logic [31:0] exp_stall = 32'd0;
    vec_t        vecs[20];

    always #5 clk = ~clk;

    pipe_ctrl #(.MEM_TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .id_rj(id_rj), .id_rk(id_rk), .id_rj_re(id_rj_re), .id_rk_re(id_rk_re),
        .exe_reg_d(exe_reg_d), .mm1_reg_d(mm1_reg_d),
        .exe_reg_d_wen(exe_reg_d_wen), .exe_mm_re(exe_mm_re),
        .mm1_reg_d_wen(mm1_reg_d_wen), .mm1_mm_re(mm1_mm_re),
        .exe_md_start(exe_md_start), .md_done(md_done), .exe_br_taken(exe_br_taken),
        .if_valid(if_valid), .mm1_mm_req(mm1_mm_req), .dmem_req_ack(dmem_req_ack),
        .mm2_mm_re(mm2_mm_re), .dmem_rdata_valid(dmem_rdata_valid), .wb_excp(wb_excp),
        .wen_pc(wen_pc), .wen_if_id(wen_if_id), .wen_id_exe(wen_id_exe),
        .wen_exe_mm1(wen_exe_mm1), .wen_mm1_mm2(wen_mm1_mm2), .wen_mm2_wb(wen_mm2_wb),
        .flush_if_id(flush_if_id), .flush_id_exe(flush_id_exe),
        .flush_exe_mm1(flush_exe_mm1), .flush_mm1_mm2(flush_mm1_mm2),
        .flush_mm2_wb(flush_mm2_wb),
        .md_ack(md_ack), .md_cancel(md_cancel),
        .stall_cnt(stall_cnt), .mem_timeout_err(mem_timeout_err)
    );

    function automatic vec_t mk(input string name, input logic [4:0] rj, input logic [4:0] rk,
                                input logic [4:0] exe_d, input logic [4:0] mm1_d,
                                input logic [13:0] flags, input logic [5:0] e_wen,
                                input logic [4:0] e_flush, input logic e_ack,
                                input logic e_cancel);
        vec_t v;
        v.name = name; v.rj = rj; v.rk = rk; v.exe_d = exe_d; v.mm1_d = mm1_d;
        v.flags = flags; v.e_wen = e_wen; v.e_flush = e_flush;
        v.e_ack = e_ack; v.e_cancel = e_cancel;
        return v;
    endfunction

    task automatic set_in(input logic [4:0] rj, input logic [4:0] rk, input logic [4:0] exe_d,
                          input logic [4:0] mm1_d, input logic [13:0] f);
        id_rj            = rj;
        id_rk            = rk;
        exe_reg_d        = exe_d;
        mm1_reg_d        = mm1_d;
        id_rj_re         = |(f & F_RJ_RE);
        id_rk_re         = |(f & F_RK_RE);
        exe_reg_d_wen    = |(f & (F_EXE_LD | F_EXE_WEN));
        exe_mm_re        = |(f & F_EXE_LD);
        mm1_reg_d_wen    = |(f & F_MM1_LD);
        mm1_mm_re        = |(f & F_MM1_LD);
        exe_md_start     = |(f & F_MD_START);
        md_done          = |(f & F_MD_DONE);
        exe_br_taken     = |(f & F_BR);
        if_valid         = ~|(f & F_FB);
        mm1_mm_req       = |(f & F_MM1_REQ);
        dmem_req_ack     = |(f & F_REQ_ACK);
        mm2_mm_re        = |(f & F_MM2_RE);
        dmem_rdata_valid = |(f & F_RVALID);
        wb_excp          = |(f & F_EXCP);
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    // Checks the controls mid-cycle, then advances one edge and tracks the stall count.
    task automatic step_check(input string name, input logic [5:0] e_wen,
                              input logic [4:0] e_flush, input logic e_ack, input logic e_cancel);
        logic [12:0] got;
        logic [12:0] exp;
        @(negedge clk);
        got = {wen_mm2_wb, wen_mm1_mm2, wen_exe_mm1, wen_id_exe, wen_if_id, wen_pc,
               flush_mm2_wb, flush_mm1_mm2, flush_exe_mm1, flush_id_exe, flush_if_id,
               md_ack, md_cancel};
        exp = {e_wen, e_flush, e_ack, e_cancel};
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got wen/flush/ack/cancel=%b expected %b", name, got, exp);
        if (!e_wen[0] && !rst) exp_stall = exp_stall + 32'd1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vecs[0]  = mk("idle",          0, 0, 0, 0, 14'h0,                        W_ALL,  5'b00000, 0, 0);
        vecs[1]  = mk("lu_exe_rj",     5, 0, 5, 0, F_RJ_RE | F_EXE_LD,           W_LU,   5'b00010, 0, 0);
        vecs[2]  = mk("lu_exe_rk",     1, 7, 7, 0, F_RK_RE | F_EXE_LD,           W_LU,   5'b00010, 0, 0);
        vecs[3]  = mk("lu_mm1_rj",     9, 0, 0, 9, F_RJ_RE | F_MM1_LD,           W_LU,   5'b00010, 0, 0);
        vecs[4]  = mk("lu_r0",         0, 0, 0, 0, F_RJ_RE | F_EXE_LD,           W_ALL,  5'b00000, 0, 0);
        vecs[5]  = mk("lu_no_re",      5, 0, 5, 0, F_EXE_LD,                     W_ALL,  5'b00000, 0, 0);
        vecs[6]  = mk("lu_not_load",   5, 0, 5, 0, F_RJ_RE | F_EXE_WEN,          W_ALL,  5'b00000, 0, 0);
        vecs[7]  = mk("fetch_bubble",  0, 0, 0, 0, F_FB,                         W_ALL,  5'b00001, 0, 0);
        vecs[8]  = mk("branch",        0, 0, 0, 0, F_BR,                         W_ALL,  5'b00011, 0, 0);
        vecs[9]  = mk("branch_lu",     5, 0, 5, 0, F_BR | F_RJ_RE | F_EXE_LD,    W_ALL,  5'b00011, 0, 0);
        vecs[10] = mk("branch_fb",     0, 0, 0, 0, F_BR | F_FB,                  W_ALL,  5'b00011, 0, 0);
        vecs[11] = mk("mem_req",       0, 0, 0, 0, F_MM1_REQ,                    W_MEMR, 5'b10000, 0, 0);
        vecs[12] = mk("mem_req_acked", 0, 0, 0, 0, F_MM1_REQ | F_REQ_ACK,        W_ALL,  5'b00000, 0, 0);
        vecs[13] = mk("mem_data",      0, 0, 0, 0, F_MM2_RE,                     W_NONE, 5'b00000, 0, 0);
        vecs[14] = mk("memd_over_memr",0, 0, 0, 0, F_MM2_RE | F_MM1_REQ,         W_NONE, 5'b00000, 0, 0);
        vecs[15] = mk("memr_over_br",  5, 0, 5, 0, F_MM1_REQ | F_BR | F_RJ_RE | F_EXE_LD,
                                                                                 W_MEMR, 5'b10000, 0, 0);
        vecs[16] = mk("excp_over_memd",0, 0, 0, 0, F_EXCP | F_MM2_RE,            W_ALL,  5'b11111, 0, 1);
        vecs[17] = mk("md_same_cycle", 0, 0, 0, 0, F_MD_START | F_MD_DONE,       W_ALL,  5'b00000, 1, 0);
        vecs[18] = mk("md_done_memr",  0, 0, 0, 0, F_MD_START | F_MD_DONE | F_MM1_REQ,
                                                                                 W_MEMR, 5'b10000, 0, 0);
        vecs[19] = mk("excp_md_start", 0, 0, 0, 0, F_EXCP | F_MD_START,          W_ALL,  5'b11111, 0, 1);

        // Reset: controls follow the idle equations while rst is held.
        rst = 1'b1;
        set_in(0, 0, 0, 0, 14'h0);
        @(posedge clk);
        #1;
        step_check("reset_idle", W_ALL, 5'b00000, 0, 0);
        check_val("reset_stall_cnt", stall_cnt, 32'd0);
        check_val("reset_timeout_err", {31'd0, mem_timeout_err}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            set_in(vecs[i].rj, vecs[i].rk, vecs[i].exe_d, vecs[i].mm1_d, vecs[i].flags);
            step_check(vecs[i].name, vecs[i].e_wen, vecs[i].e_flush, vecs[i].e_ack,
                       vecs[i].e_cancel);
        end
        check_val("table_stall_cnt", stall_cnt, exp_stall);
        check_val("table_timeout_err", {31'd0, mem_timeout_err}, 32'd0);

        // Load walks from EXE to MM1: two stall cycles, then free.
        set_in(5, 0, 5, 0, F_RJ_RE | F_EXE_LD);
        step_check("lu_seq_exe", W_LU, 5'b00010, 0, 0);
        set_in(5, 0, 0, 5, F_RJ_RE | F_MM1_LD);
        step_check("lu_seq_mm1", W_LU, 5'b00010, 0, 0);
        set_in(5, 0, 0, 0, F_RJ_RE);
        step_check("lu_seq_clear", W_ALL, 5'b00000, 0, 0);

        // Mul/div with a branch waiting in EXE until the result arrives.
        set_in(0, 0, 0, 0, F_MD_START);
        step_check("md_issue", W_MD, 5'b00100, 0, 0);
        for (int k = 1; k <= 3; k++) begin
            set_in(0, 0, 0, 0, F_BR);
            step_check($sformatf("md_busy_br_%0d", k), W_MD, 5'b00100, 0, 0);
        end
        set_in(0, 0, 0, 0, F_BR | F_MD_DONE);
        step_check("md_done_br", W_ALL, 5'b00011, 1, 0);
        set_in(0, 0, 0, 0, 14'h0);
        step_check("md_back_idle", W_ALL, 5'b00000, 0, 0);
        check_val("md_stall_cnt", stall_cnt, exp_stall);

        // Request accept delayed 3 cycles, then 2 cycles of missing read data.
        for (int k = 1; k <= 3; k++) begin
            set_in(0, 0, 0, 0, F_MM1_REQ);
            step_check($sformatf("memr_wait_%0d", k), W_MEMR, 5'b10000, 0, 0);
        end
        set_in(0, 0, 0, 0, F_MM1_REQ | F_REQ_ACK);
        step_check("memr_accept", W_ALL, 5'b00000, 0, 0);
        for (int k = 1; k <= 2; k++) begin
            set_in(0, 0, 0, 0, F_MM2_RE);
            step_check($sformatf("memd_wait_%0d", k), W_NONE, 5'b00000, 0, 0);
        end
        set_in(0, 0, 0, 0, F_MM2_RE | F_RVALID);
        step_check("memd_valid", W_ALL, 5'b00000, 0, 0);

        // Exception during MD_BUSY with a request stall: flush all, cancel, then IDLE.
        set_in(0, 0, 0, 0, F_MD_START);
        step_check("excp_md_issue", W_MD, 5'b00100, 0, 0);
        set_in(0, 0, 0, 0, F_EXCP | F_MM1_REQ);
        step_check("excp_in_busy", W_ALL, 5'b11111, 0, 1);
        set_in(0, 0, 0, 0, 14'h0);
        step_check("excp_then_idle", W_ALL, 5'b00000, 0, 0);

        // Timeout: request stall held 10 cycles against MEM_TIMEOUT=8.
        for (int k = 1; k <= 10; k++) begin
            set_in(0, 0, 0, 0, F_MM1_REQ);
            step_check($sformatf("tmo_stall_%0d", k), W_MEMR, 5'b10000, 0, 0);
            check_val($sformatf("tmo_err_after_%0d", k), {31'd0, mem_timeout_err},
                      (k >= 8) ? 32'd1 : 32'd0);
        end
        set_in(0, 0, 0, 0, 14'h0);
        step_check("tmo_release", W_ALL, 5'b00000, 0, 0);
        step_check("tmo_release_2", W_ALL, 5'b00000, 0, 0);
        check_val("tmo_err_sticky", {31'd0, mem_timeout_err}, 32'd1);
        check_val("tmo_stall_cnt", stall_cnt, exp_stall);

        // Reset while MD_BUSY: idle equations under rst, IDLE afterwards.
        set_in(0, 0, 0, 0, F_MD_START);
        step_check("rst_md_issue", W_MD, 5'b00100, 0, 0);
        rst = 1'b1;
        set_in(0, 0, 0, 0, 14'h0);
        step_check("rst_in_busy", W_ALL, 5'b00000, 0, 0);
        exp_stall = 32'd0;
        rst = 1'b0;
        step_check("rst_after_idle", W_ALL, 5'b00000, 0, 0);
        check_val("rst_stall_cnt", stall_cnt, exp_stall);
        check_val("rst_timeout_err", {31'd0, mem_timeout_err}, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
